// File: rtl/pe_pkg.sv
// pe_pkg: shared types, default widths and saturation helpers for the partial-sum accumulator
package pe_pkg;
  localparam int WID_D = 16;
  localparam int ACC_W_D = WID_D + 4;
  localparam int OFIFO_D = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} psum_state_t;
  function automatic logic signed [ACC_W_D-1:0] sat_acc(input logic signed [ACC_W_D:0] x);
    logic signed [ACC_W_D:0] mx;
    logic signed [ACC_W_D:0] mn;
    mx = {2'b00, {(ACC_W_D-1){1'b1}}};
    mn = {2'b11, {(ACC_W_D-1){1'b0}}};
    return x > mx ? mx[ACC_W_D-1:0] : x < mn ? mn[ACC_W_D-1:0] : x[ACC_W_D-1:0];
  endfunction
  function automatic logic signed [WID_D-1:0] sat_wid(input logic signed [ACC_W_D-1:0] x);
    logic signed [ACC_W_D-1:0] mx;
    logic signed [ACC_W_D-1:0] mn;
    mx = {{(ACC_W_D-WID_D+1){1'b0}}, {(WID_D-1){1'b1}}};
    mn = {{(ACC_W_D-WID_D+1){1'b1}}, {(WID_D-1){1'b0}}};
    return x > mx ? mx[WID_D-1:0] : x < mn ? mn[WID_D-1:0] : x[WID_D-1:0];
  endfunction
endpackage

// File: rtl/psum_accumulator_ram.sv
// psum_sdp_ram: simple dual-port partial-sum buffer, registered read-first output
module psum_sdp_ram #(
  parameter int W = 20,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates PE outputs across filter banks; saturates and streams results on the final bank (optional PSUM_BIAS_EN adds a first-bank bias)
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int WID = WID_D,
  parameter int ACC_W = ACC_W_D,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_pixels,
  input  logic                 first_bank,
  input  logic                 final_bank,
`ifdef PSUM_BIAS_EN
  input  logic [WID-1:0]       bias_in,
  input  logic                 bias_load,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WID:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID-1:0]       out_data,
  output logic                 busy,
  output logic                 done
);
  localparam int FW = $clog2(OFIFO_D);
  psum_state_t state, nxt;
  logic [ADDR_W:0] n_px, cnt;
  logic fb, fin, v1, accept, push, pop;
  logic signed [WID:0] d1;
  logic [ADDR_W-1:0] a1;
  logic [ACC_W-1:0] q;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0] base, ext_d;
  logic [WID-1:0] fifo [OFIFO_D];
  logic [FW-1:0] wp, rp;
  logic [FW:0] fcnt;
`ifdef PSUM_BIAS_EN
  logic [WID-1:0] bias;
  assign base = {{(ACC_W+1-WID){bias[WID-1]}}, bias};
`else
  assign base = '0;
`endif
  assign in_ready = state == RUN && cnt < n_px &&
                    (!fin || ({1'b0, fcnt} + (FW+2)'(v1)) < (FW+2)'(OFIFO_D));
  assign accept = in_valid && in_ready;
  assign push = v1 && fin;
  assign out_valid = fcnt != '0;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? fifo[rp] : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ext_d = {{(ACC_W-WID){d1[WID]}}, d1};
  assign sum = sat_acc((fb ? base : {q[ACC_W-1], q}) + ext_d);
  psum_sdp_ram #(.W(ACC_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram (
    .clk(clk),
    .we(v1),
    .waddr(a1),
    .wdata(sum),
    .re(accept && !fb),
    .raddr(cnt[ADDR_W-1:0]),
    .rdata(q)
  );
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = num_pixels == '0 ? DONE : RUN;
    else if (state == RUN && cnt == n_px) nxt = DRAIN;
    else if (state == DRAIN && !v1 && (!fin || fcnt == '0)) nxt = DONE;
    else if (state == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      v1 <= 1'b0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
      v1 <= accept;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fcnt <= fcnt + (FW+1)'(push) - (FW+1)'(pop);
    end
  end
  // pass configuration and datapath registers need no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      n_px <= num_pixels;
      fb <= first_bank;
      fin <= final_bank;
`ifdef PSUM_BIAS_EN
      bias <= bias_load ? bias_in : '0;
`endif
    end
    d1 <= in_data;
    a1 <= cnt[ADDR_W-1:0];
    if (push) fifo[wp] <= sat_wid(sum);
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed self-checking bench for psum_accumulator (honours PSUM_BIAS_EN)
module tb_psum_accumulator;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, first_bank = 1'b0, final_bank = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [10:0] num_pixels = '0;
  logic signed [16:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [15:0] out_data;
`ifdef PSUM_BIAS_EN
  logic [15:0] bias_in = '0;
  logic bias_load = 1'b0;
`endif
  int vecs = 0, errs = 0, dcnt = 0, ovc = 0, d0, o0;
  logic signed [15:0] got[$];

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_pixels(num_pixels),
    .first_bank(first_bank),
    .final_bank(final_bank),
`ifdef PSUM_BIAS_EN
    .bias_in(bias_in),
    .bias_load(bias_load),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .done(done)
  );

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (out_valid) ovc++;
    if (done) dcnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pass(input int n, input logic fb, input logic fin);
    num_pixels = n[10:0];
    first_bank = fb;
    final_bank = fin;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int d);
    int t = 0;
    in_valid = 1'b1;
    in_data = d[16:0];
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      step();
      t++;
    end
    chk("done_seen", done, 1);
    step();
  endtask

  task automatic check_all(input string tag, input int n, input int v);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) chk(tag, got[i], v);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    got.delete();
    d0 = dcnt;
    pass(4, 1, 1);
    chk("t1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) send(i);
    wait_done();
    repeat (3) step();
    chk("t1_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("t1_data", got[i], i + 1);
    chk("t1_done_once", dcnt - d0, 1);

    got.delete();
    o0 = ovc;
    pass(8, 1, 0);
    repeat (8) send(100);
    wait_done();
    chk("t2_bank0_no_valid", ovc - o0, 0);
    pass(8, 0, 1);
    repeat (8) send(-30);
    wait_done();
    step();
    check_all("t2_sum", 8, 70);

    got.delete();
    pass(2, 1, 0);
    repeat (2) send(32767);
    wait_done();
    pass(2, 0, 0);
    repeat (2) send(32767);
    wait_done();
    pass(2, 0, 1);
    repeat (2) send(32767);
    wait_done();
    step();
    check_all("t3_sat_pos", 2, 32767);
    got.delete();
    pass(2, 1, 0);
    repeat (2) send(-32768);
    wait_done();
    pass(2, 0, 0);
    repeat (2) send(-32768);
    wait_done();
    pass(2, 0, 1);
    repeat (2) send(-32768);
    wait_done();
    step();
    check_all("t3_sat_neg", 2, -32768);

    got.delete();
    out_ready = 1'b0;
    pass(16, 1, 1);
    for (int i = 0; i < 4; i++) send(i * 3 - 5);
    in_valid = 1'b1;
    in_data = 17'sd7;
    repeat (4) step();
    chk("t4_backpressure", in_ready, 0);
    chk("t4_held_valid", out_valid, 1);
    chk("t4_nothing_popped", got.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 4; i < 16; i++) send(i * 3 - 5);
    wait_done();
    step();
    chk("t4_count", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("t4_order", got[i], i * 3 - 5);

    pass(8, 1, 1);
    send(7);
    send(8);
    rst = 1'b1;
    step();
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    got.delete();
    d0 = dcnt;
    pass(0, 1, 1);
    chk("t5_zero_done", done, 1);
    step();
    repeat (3) step();
    chk("t5_zero_no_out", got.size(), 0);
    chk("t5_zero_done_once", dcnt - d0, 1);
    chk("t5_zero_idle", busy, 0);

    got.delete();
`ifdef PSUM_BIAS_EN
    bias_in = 16'd5;
    bias_load = 1'b1;
`endif
    pass(1, 1, 1);
    send(10);
    wait_done();
    step();
    chk("t6_count", got.size(), 1);
`ifdef PSUM_BIAS_EN
    if (got.size() > 0) chk("t6_bias", got[0], 15);
`else
    if (got.size() > 0) chk("t6_nobias", got[0], 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
